fetch_seq_param: RTL and testbench

Parametrised successor to the LC-3 fetch unit. It sequences one instruction's control-flow and memory-address phases after each fetch_start pulse.
- Redirects PC for BR/JMP/JSR.
- Issues effective-address accesses for LD/ST and two-phase indirect accesses for LDI/STI, with configurable memory read latency.
- Finishes with the next instruction fetch.
- Sits between the decode stage and the unified instruction/data memory port.

---
 rtl/lc3_pkg.sv | 30 +++
 rtl/fetch_ea_adder.sv | 16 +
 rtl/fetch_seq_param.sv | 146 ++++++++++++++
 tb/tb_fetch_seq_param.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared definitions for the parametrised LC-3 fetch sequencer:
// opcode constants, sequencer state encoding and a sign-extension helper.
package lc3_pkg;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_JSR = 4'b0100;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;

   // Wide enough to hold the largest supported read latency (4).
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EA,
      ST_IND_WAIT,
      ST_FETCH
   } state_t;

   // Sign-extends the low w bits of v to 32 bits; callers truncate to their width.
   function automatic logic [31:0] sext(input logic [31:0] v, input int w);
      logic [31:0] t;
      t = v << (32 - w);
      return 32'($signed(t) >>> (32 - w));
   endfunction

endpackage

// File: rtl/fetch_ea_adder.sv
// Effective-address adder: base + sign-extended offset, modulo 2^ADDR_W.
// Shared by the BR/JSR branch target and the LD/ST/LDI/STI data address.
module fetch_ea_adder
   import lc3_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int OFF_W  = 9
) (
   input  logic [ADDR_W-1:0] base,
   input  logic [OFF_W-1:0]  offset,
   output logic [ADDR_W-1:0] sum
);

   assign sum = ADDR_W'(32'(base) + sext(32'(offset), OFF_W));

endmodule

// File: rtl/fetch_seq_param.sv
// Fetch sequencer: after each accepted fetch_start it runs the control-flow /
// effective-address phase of the latched instruction, an optional indirect
// pointer phase, and finally the next instruction fetch.
module fetch_seq_param
   import lc3_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter int                OFF_W    = 9,
   parameter int                MEM_LAT  = 1,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_start,
   input  logic [3:0]        opCode_in,
   input  logic [OFF_W-1:0]  offset_in,
   input  logic [ADDR_W-1:0] reg_in,
   input  logic [2:0]        br_nzp,
   input  logic [2:0]        result_nzp,
   input  logic [ADDR_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] addr_out,
   output logic              wea_out,
   output logic              mem_en,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              done
);

   state_t            state, state_nxt;
   logic [3:0]        op_q;
   logic [OFF_W-1:0]  off_q;
   logic [ADDR_W-1:0] reg_q;
   logic [2:0]        br_q, cc_q;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ADDR_W-1:0] ea;
   logic [ADDR_W-1:0] pc_nxt, addr_nxt;
   logic              wea_nxt, en_nxt, done_nxt;

   fetch_ea_adder #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) u_ea (
      .base   (pc),
      .offset (off_q),
      .sum    (ea)
   );

   assign busy = (state != ST_IDLE);

   // State register plus the instruction fields captured when a start is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         op_q  <= '0;
         off_q <= '0;
         reg_q <= '0;
         br_q  <= '0;
         cc_q  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == ST_IDLE && fetch_start) begin
            op_q  <= opCode_in;
            off_q <= offset_in;
            reg_q <= reg_in;
            br_q  <= br_nzp;
            cc_q  <= result_nzp;
         end
      end
   end

   // Next-state selection; only indirect ops take the pointer-wait detour.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (fetch_start) state_nxt = ST_EA;
         ST_EA:       state_nxt = (op_q == OP_LDI || op_q == OP_STI) ? ST_IND_WAIT : ST_FETCH;
         ST_IND_WAIT: if (cnt <= CNT_W'(1)) state_nxt = ST_FETCH;
         ST_FETCH:    state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered memory-port outputs, PC and latency counter.
   always_comb begin
      pc_nxt   = pc;
      addr_nxt = addr_out;
      wea_nxt  = 1'b0;
      en_nxt   = 1'b0;
      done_nxt = 1'b0;
      cnt_nxt  = cnt;
      case (state)
         ST_EA: begin
            case (op_q)
               OP_BR:  if ((br_q & cc_q) != 3'b000) pc_nxt = ea;
               OP_JMP: pc_nxt = reg_q;
               OP_JSR: pc_nxt = ea;
               OP_LD, OP_ST: begin
                  addr_nxt = ea;
                  en_nxt   = 1'b1;
                  wea_nxt  = (op_q == OP_ST);
               end
               OP_LDI, OP_STI: begin
                  addr_nxt = ea;
                  en_nxt   = 1'b1;
                  cnt_nxt  = CNT_W'(MEM_LAT);
               end
               default: ;
            endcase
         end
         ST_IND_WAIT: begin
            if (cnt <= CNT_W'(1)) begin
               addr_nxt = mem_rdata;
               en_nxt   = 1'b1;
               wea_nxt  = (op_q == OP_STI);
               cnt_nxt  = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_FETCH: begin
            addr_nxt = pc;
            pc_nxt   = pc + ADDR_W'(1);
            en_nxt   = 1'b1;
            done_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   // Registered outputs; reset abandons any in-flight access.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         addr_out <= '0;
         wea_out  <= 1'b0;
         mem_en   <= 1'b0;
         done     <= 1'b0;
      end else begin
         pc       <= pc_nxt;
         addr_out <= addr_nxt;
         wea_out  <= wea_nxt;
         mem_en   <= en_nxt;
         done     <= done_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_seq_param.sv
// Self-checking bench for fetch_seq_param: reset behaviour, a directed vector
// table, hand-written multi-cycle corner cases and randomized instructions
// checked against a transaction-level reference model.
module tb_fetch_seq_param;

   localparam int ADDR_W  = 16;
   localparam int OFF_W   = 9;
   localparam int MEM_LAT = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              fetch_start;
   logic [3:0]        opCode_in;
   logic [OFF_W-1:0]  offset_in;
   logic [ADDR_W-1:0] reg_in;
   logic [2:0]        br_nzp;
   logic [2:0]        result_nzp;
   logic [ADDR_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] addr_out;
   logic              wea_out;
   logic              mem_en;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              done;

   fetch_seq_param #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .MEM_LAT(MEM_LAT), .RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_start (fetch_start),
      .opCode_in   (opCode_in),
      .offset_in   (offset_in),
      .reg_in      (reg_in),
      .br_nzp      (br_nzp),
      .result_nzp  (result_nzp),
      .mem_rdata   (mem_rdata),
      .addr_out    (addr_out),
      .wea_out     (wea_out),
      .mem_en      (mem_en),
      .pc          (pc),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Memory contents: address 0x0010 holds the pointer 0x4000, the rest is a hash.
   function automatic logic [15:0] memFunc(input logic [15:0] a);
      if (a == 16'h0010) return 16'h4000;
      return {a[7:0], a[15:8]} ^ 16'h1234;
   endfunction

   // Read data follows the address bus; the DUT decides when to sample it.
   always_comb mem_rdata = memFunc(addr_out);

   int checkCnt = 0;
   int passCnt  = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCnt++;
      if (act === exp) passCnt++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference model: the architectural effect of one instruction as a list of
   // memory accesses, a start-to-done latency and the resulting PC.
   logic [15:0] pcModel;
   logic [15:0] expAddr[$];
   logic        expWea[$];
   int          expLat;

   task automatic modelInstr(input logic [3:0] op, input logic [8:0] off, input logic [15:0] regv,
                             input logic [2:0] br, input logic [2:0] cc);
      logic [15:0] ea, target;
      ea = pcModel + {{7{off[8]}}, off};
      target = pcModel;
      expAddr.delete();
      expWea.delete();
      expLat = 2;
      case (op)
         4'b0000: if ((br & cc) != 3'b000) target = ea;
         4'b1100: target = regv;
         4'b0100: target = ea;
         4'b0010, 4'b0011: begin
            expAddr.push_back(ea);
            expWea.push_back(op == 4'b0011);
         end
         4'b1010, 4'b1011: begin
            expAddr.push_back(ea);
            expWea.push_back(1'b0);
            expAddr.push_back(memFunc(ea));
            expWea.push_back(op == 4'b1011);
            expLat = 2 + MEM_LAT;
         end
         default: ;
      endcase
      expAddr.push_back(target);
      expWea.push_back(1'b0);
      pcModel = target + 16'd1;
   endtask

   // Observations of one instruction's run.
   logic [15:0] obsAddr[$];
   logic        obsWea[$];
   int          obsLat;
   int          busyErr;
   logic        busyAtDone;

   // Starts one instruction and records every access until done (bounded).
   // With spurious set, fetch_start stays high for every busy edge and the
   // edge on which the sequencer returns to idle.
   task automatic applyStimulus(input logic [3:0] op, input logic [8:0] off, input logic [15:0] regv,
                                input logic [2:0] br, input logic [2:0] cc, input bit spurious);
      obsAddr.delete();
      obsWea.delete();
      obsLat = -1;
      busyErr = 0;
      busyAtDone = 1'bx;
      @(negedge clk);
      opCode_in = op; offset_in = off; reg_in = regv; br_nzp = br; result_nzp = cc;
      fetch_start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (!spurious) fetch_start = 1'b0;
         if (c == 1) begin
            opCode_in = 4'($urandom); offset_in = 9'($urandom); reg_in = 16'($urandom);
            br_nzp = 3'($urandom); result_nzp = 3'($urandom);
         end
         if (mem_en) begin
            obsAddr.push_back(addr_out);
            obsWea.push_back(wea_out);
         end
         if (done) begin
            obsLat = c - 1;
            busyAtDone = busy;
            break;
         end
         if (!busy) busyErr++;
      end
      fetch_start = 1'b0;
   endtask

   task automatic runAndCompare(input string name, input logic [3:0] op, input logic [8:0] off,
                                input logic [15:0] regv, input logic [2:0] br, input logic [2:0] cc,
                                input bit spurious);
      int n;
      modelInstr(op, off, regv, br, cc);
      applyStimulus(op, off, regv, br, cc, spurious);
      checkOutput({name, " latency"}, obsLat, expLat);
      checkOutput({name, " access count"}, obsAddr.size(), expAddr.size());
      n = (obsAddr.size() < expAddr.size()) ? obsAddr.size() : expAddr.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s access%0d addr", name, i), obsAddr[i], expAddr[i]);
         checkOutput($sformatf("%s access%0d wea", name, i), obsWea[i], expWea[i]);
      end
      checkOutput({name, " pc"}, pc, pcModel);
      checkOutput({name, " busy during run/at done"}, {busyErr, busyAtDone}, 33'd0);
      @(negedge clk);
      checkOutput({name, " idle after done"}, {busy, done, mem_en, wea_out}, 4'b0000);
   endtask

   task automatic doReset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      fetch_start = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      pcModel = 16'h0000;
   endtask

   typedef struct {
      string             name;
      logic [3:0]        op;
      logic [8:0]        off;
      logic [15:0]       regv;
      logic [2:0]        br;
      logic [2:0]        cc;
      int                nAcc;
      logic [2:0][15:0]  acc;
      logic [2:0]        accW;
      logic [15:0]       pcExp;
      int                lat;
   } vec_t;

   vec_t vecs[9];

   initial begin
      rst = 1'b1; fetch_start = 1'b0; opCode_in = 4'b1010; offset_in = '0;
      reg_in = '0; br_nzp = '0; result_nzp = '0; pcModel = 16'h0000;

      // Reset held with an LDI opcode presented but no start.
      repeat (5) @(negedge clk);
      checkOutput("in reset", {addr_out, pc, busy, mem_en, wea_out, done}, 36'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput($sformatf("post-reset idle %0d", i), {addr_out, pc, busy, mem_en, wea_out, done}, 36'd0);
      end

      // Directed table; every row starts from pc = 0 after reset (MEM_LAT = 2).
      vecs[0] = '{"BR taken wrap", 4'b0000, 9'h1FE, 16'h0, 3'b010, 3'b010, 1, {16'h0, 16'h0, 16'hFFFE}, 3'b000, 16'hFFFF, 2};
      vecs[1] = '{"BR not taken",  4'b0000, 9'h005, 16'h0, 3'b100, 3'b001, 1, {16'h0, 16'h0, 16'h0000}, 3'b000, 16'h0001, 2};
      vecs[2] = '{"LDI",           4'b1010, 9'h010, 16'h0, 3'b000, 3'b000, 3, {16'h0000, 16'h4000, 16'h0010}, 3'b000, 16'h0001, 4};
      vecs[3] = '{"STI",           4'b1011, 9'h010, 16'h0, 3'b000, 3'b000, 3, {16'h0000, 16'h4000, 16'h0010}, 3'b010, 16'h0001, 4};
      vecs[4] = '{"JMP",           4'b1100, 9'h000, 16'h1234, 3'b000, 3'b000, 1, {16'h0, 16'h0, 16'h1234}, 3'b000, 16'h1235, 2};
      vecs[5] = '{"JSR",           4'b0100, 9'h0FF, 16'h0, 3'b000, 3'b000, 1, {16'h0, 16'h0, 16'h00FF}, 3'b000, 16'h0100, 2};
      vecs[6] = '{"LD negative",   4'b0010, 9'h100, 16'h0, 3'b000, 3'b000, 2, {16'h0, 16'h0000, 16'hFF00}, 3'b000, 16'h0001, 2};
      vecs[7] = '{"ST",            4'b0011, 9'h007, 16'h0, 3'b000, 3'b000, 2, {16'h0, 16'h0000, 16'h0007}, 3'b001, 16'h0001, 2};
      vecs[8] = '{"NOP",           4'b0001, 9'h0AB, 16'h0, 3'b111, 3'b111, 1, {16'h0, 16'h0, 16'h0000}, 3'b000, 16'h0001, 2};

      foreach (vecs[v]) begin
         doReset(2);
         applyStimulus(vecs[v].op, vecs[v].off, vecs[v].regv, vecs[v].br, vecs[v].cc, 1'b0);
         checkOutput({vecs[v].name, " latency"}, obsLat, vecs[v].lat);
         checkOutput({vecs[v].name, " access count"}, obsAddr.size(), vecs[v].nAcc);
         for (int i = 0; i < vecs[v].nAcc && i < obsAddr.size(); i++) begin
            checkOutput($sformatf("%s access%0d addr", vecs[v].name, i), obsAddr[i], vecs[v].acc[i]);
            checkOutput($sformatf("%s access%0d wea", vecs[v].name, i), obsWea[i], vecs[v].accW[i]);
         end
         checkOutput({vecs[v].name, " pc"}, pc, vecs[v].pcExp);
         @(negedge clk);
         checkOutput({vecs[v].name, " done one cycle"}, {done, busy}, 2'b00);
      end

      // Start pulse during IND_WAIT is ignored, then reset abandons the pointer access.
      doReset(2);
      opCode_in = 4'b1010; offset_in = 9'h010; fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      @(negedge clk);
      checkOutput("ind abort first access", {addr_out, mem_en, wea_out}, {16'h0010, 2'b10});
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      checkOutput("ind abort waiting", {busy, mem_en, wea_out, done}, 4'b1000);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("ind abort reset values", {addr_out, pc, busy, mem_en, wea_out, done}, 36'd0);
      begin
         int bad = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wea_out || mem_en || busy || addr_out == 16'h4000) bad++;
         end
         checkOutput("ind abort no late access", bad, 0);
      end

      // Randomized instructions against the reference model, pc carried across.
      doReset(2);
      for (int k = 0; k < 60; k++) begin
         logic [3:0] rop;
         case ($urandom_range(0, 3))
            0: rop = 4'b1010 | 4'($urandom_range(0, 1));
            1: rop = 4'b0010 | 4'($urandom_range(0, 1));
            default: rop = 4'($urandom);
         endcase
         runAndCompare($sformatf("rand%0d", k), rop, 9'($urandom), 16'($urandom),
                       3'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0));
      end

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
